// File: rtl/pontuacao_pkg.sv
// rtl/pontuacao_pkg.sv - shared state type and constant helpers for the score engine
package pontuacao_pkg;

  typedef enum logic [1:0] {IDLE, DIV, ACCUM} state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) res++;
    return res;
  endfunction

  function automatic int sum_rounds(input int n);
    return n * (n + 1) / 2;
  endfunction

endpackage

// File: rtl/pontuacao_seq_divider.sv
// rtl/pontuacao_seq_divider.sv - restoring divider, one quotient bit per cycle
module seq_divider
  import pontuacao_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CW = clog2(W + 1);

  logic [W-1:0]  num;
  logic [W-1:0]  rem;
  logic [W-1:0]  div_q;
  logic [CW-1:0] cnt;
  logic          active;
  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  diff;

  // When ge holds the difference is below the divisor, so W bits suffice.
  assign trial = {rem, num[W-1]};
  assign ge    = trial >= {1'b0, div_q};
  assign diff  = trial[W-1:0] - div_q;
  assign done  = active && (cnt == CW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      num      <= '0;
      rem      <= '0;
      div_q    <= '0;
      quotient <= '0;
      cnt      <= '0;
      active   <= 1'b0;
    end else if (start) begin
      num      <= dividend;
      div_q    <= divisor;
      rem      <= '0;
      quotient <= '0;
      cnt      <= CW'(W);
      active   <= 1'b1;
    end else if (active) begin
      rem      <= ge ? diff : trial[W-1:0];
      num      <= {num[W-2:0], 1'b0};
      quotient <= {quotient[W-2:0], ge};
      cnt      <= cnt - CW'(1);
      if (cnt == CW'(1)) active <= 1'b0;
    end
  end

endmodule

// File: rtl/pontuacao_seq.sv
// rtl/pontuacao_seq.sv - sequential score engine: request FSM, divider, penalty/clamp and sticky flags
module pontuacao_seq
  import pontuacao_pkg::*;
#(
  parameter int MAX_SCORE = 100,
  parameter int SCORE_W   = 7,
  parameter int ROUNDS_LO = 8,
  parameter int ROUNDS_HI = 16,
  parameter int ROUND_W   = 4,
  parameter int ERR_W     = 4,
  parameter int PENALTY   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               nivel,
  input  logic               round_done,
  input  logic [ROUND_W-1:0] round_idx,
  input  logic [ERR_W-1:0]   erros,
  output logic               busy,
  output logic               score_valid,
  output logic [SCORE_W-1:0] pontos,
  output logic               perfect,
  output logic               game_over,
  output logic [ERR_W+3:0]   total_erros,
  output logic               erro_seq
);

  localparam int PROD_W = clog2(ROUNDS_HI * MAX_SCORE + 1);
  localparam int TOT_W  = ERR_W + 4;
  localparam logic [PROD_W-1:0] S_LO = PROD_W'(sum_rounds(ROUNDS_LO));
  localparam logic [PROD_W-1:0] S_HI = PROD_W'(sum_rounds(ROUNDS_HI));

  state_t             state;
  logic               lvl_q;
  logic [ROUND_W:0]   r_q;
  logic [ERR_W-1:0]   err_q;

  logic [ROUND_W:0]   r_in;
  logic [ROUND_W:0]   n_in;
  logic [ROUND_W:0]   n_q;
  logic               accept;
  logic [PROD_W-1:0]  dividend;
  logic [PROD_W-1:0]  divisor;
  logic [PROD_W-1:0]  quotient;
  logic               div_done;

  logic [31:0]        base;
  logic [31:0]        pen;
  logic [31:0]        gain;
  logic [31:0]        tmp;
  logic [SCORE_W-1:0] new_score;
  logic [TOT_W:0]     tot_sum;
  logic [TOT_W-1:0]   tot_next;
  logic               zero_game;

  assign r_in     = {1'b0, round_idx} + (ROUND_W+1)'(1);
  assign n_in     = nivel ? (ROUND_W+1)'(ROUNDS_HI) : (ROUND_W+1)'(ROUNDS_LO);
  assign n_q      = lvl_q ? (ROUND_W+1)'(ROUNDS_HI) : (ROUND_W+1)'(ROUNDS_LO);
  assign accept   = (state == IDLE) && round_done && !clear && (r_in <= n_in) && !game_over;
  assign dividend = PROD_W'(r_in) * PROD_W'(MAX_SCORE);
  assign divisor  = nivel ? S_HI : S_LO;

  seq_divider #(.W(PROD_W)) u_div (
    .clock    (clock),
    .reset    (reset || clear),
    .start    (accept),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .done     (div_done)
  );

  // Penalty and sum are evaluated wide so neither can wrap before the clamp.
  always_comb begin
    base      = 32'(quotient);
    pen       = 32'(err_q) * 32'(PENALTY);
    gain      = (base > pen) ? (base - pen) : 32'd0;
    tmp       = 32'(pontos) + gain;
    new_score = (tmp > 32'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : tmp[SCORE_W-1:0];
    tot_sum   = {1'b0, total_erros} + (TOT_W+1)'(err_q);
    tot_next  = tot_sum[TOT_W] ? {TOT_W{1'b1}} : tot_sum[TOT_W-1:0];
    zero_game = (total_erros == '0) && (err_q == '0);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state       <= IDLE;
      lvl_q       <= 1'b0;
      r_q         <= '0;
      err_q       <= '0;
      busy        <= 1'b0;
      score_valid <= 1'b0;
      pontos      <= '0;
      perfect     <= 1'b0;
      game_over   <= 1'b0;
      total_erros <= '0;
      erro_seq    <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lvl_q <= nivel;
            r_q   <= r_in;
            err_q <= erros;
            busy  <= 1'b1;
            state <= DIV;
          end else if (round_done) begin
            erro_seq <= 1'b1;
          end
        end
        DIV: begin
          if (round_done) erro_seq <= 1'b1;
          if (div_done) state <= ACCUM;
        end
        ACCUM: begin
          if (round_done) erro_seq <= 1'b1;
          busy        <= 1'b0;
          score_valid <= 1'b1;
          total_erros <= tot_next;
          state       <= IDLE;
          // A flawless game lands exactly on the ceiling despite floor rounding.
          if (r_q == n_q) begin
            game_over <= 1'b1;
            if (zero_game) begin
              pontos  <= SCORE_W'(MAX_SCORE);
              perfect <= 1'b1;
            end else begin
              pontos  <= new_score;
            end
          end else begin
            pontos <= new_score;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pontuacao_seq.sv
// tb/tb_pontuacao_seq.sv - directed bench with a cycle-accurate scoring model for pontuacao_seq
module tb_pontuacao_seq;

  localparam int PROD_W = 11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       nivel = 1'b0;
  logic       round_done = 1'b0;
  logic [3:0] round_idx = '0;
  logic [3:0] erros = '0;
  logic       busy;
  logic       score_valid;
  logic [6:0] pontos;
  logic       perfect;
  logic       game_over;
  logic [7:0] total_erros;
  logic       erro_seq;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  pontuacao_seq dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .nivel       (nivel),
    .round_done  (round_done),
    .round_idx   (round_idx),
    .erros       (erros),
    .busy        (busy),
    .score_valid (score_valid),
    .pontos      (pontos),
    .perfect     (perfect),
    .game_over   (game_over),
    .total_erros (total_erros),
    .erro_seq    (erro_seq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs follow from the scoring rules plus the fixed accept-to-result latency.
  int m_pontos = 0, m_total = 0, m_fire = 0, m_r = 0, m_e = 0, edge_n = 0;
  bit m_perfect = 0, m_game_over = 0, m_erro_seq = 0, m_busy = 0, m_valid = 0, m_pend = 0, m_lvl = 0;

  always @(posedge clock) begin
    int n, s, base, pen, gain;
    bit was_busy;
    edge_n++;
    if (reset || clear) begin
      m_pontos = 0; m_total = 0; m_perfect = 0; m_game_over = 0;
      m_erro_seq = 0; m_busy = 0; m_valid = 0; m_pend = 0;
    end else begin
      was_busy = m_pend;
      m_valid  = 0;
      if (m_pend && edge_n == m_fire) begin
        n    = m_lvl ? 16 : 8;
        s    = n * (n + 1) / 2;
        base = m_r * 100 / s;
        pen  = m_e * 2;
        gain = (base > pen) ? base - pen : 0;
        if (m_r == n && m_total + m_e == 0) begin
          m_pontos  = 100;
          m_perfect = 1;
        end else begin
          m_pontos = (m_pontos + gain > 100) ? 100 : m_pontos + gain;
        end
        if (m_r == n) m_game_over = 1;
        m_total = (m_total + m_e > 255) ? 255 : m_total + m_e;
        m_pend = 0; m_busy = 0; m_valid = 1;
      end
      if (round_done) begin
        n = nivel ? 16 : 8;
        if (was_busy || int'(round_idx) + 1 > n || m_game_over) begin
          m_erro_seq = 1;
        end else begin
          m_pend = 1; m_busy = 1;
          m_fire = edge_n + PROD_W + 1;
          m_lvl  = nivel;
          m_r    = int'(round_idx) + 1;
          m_e    = int'(erros);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy",        32'(busy),        32'(m_busy));
      check("score_valid", 32'(score_valid), 32'(m_valid));
      check("pontos",      32'(pontos),      32'(m_pontos));
      check("perfect",     32'(perfect),     32'(m_perfect));
      check("game_over",   32'(game_over),   32'(m_game_over));
      check("total_erros", 32'(total_erros), 32'(m_total));
      check("erro_seq",    32'(erro_seq),    32'(m_erro_seq));
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input bit nv, input int idx, input int er);
    nivel      = nv;
    round_idx  = 4'(idx);
    erros      = 4'(er);
    round_done = 1'b1;
    tick();
    round_done = 1'b0;
  endtask

  task automatic play(input bit nv, input int idx, input int er, output int lat);
    pulse(nv, idx, er);
    lat = 1;
    while (!score_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("valid_seen", 32'(score_valid), 32'd1);
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_busy",   32'(busy),     32'd0);
    check("clear_pontos", 32'(pontos),   32'd0);
    check("clear_erro",   32'(erro_seq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tick();
    tick();
    chk_en = 1;
    reset  = 1'b0;
    check("rst_pontos", 32'(pontos), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_over",   32'(game_over), 32'd0);

    play(0, 0, 0, lat);
    check("latency_r1", 32'(lat),    32'd13);
    check("pontos_r1",  32'(pontos), 32'd2);

    do_clear();
    for (int i = 0; i < 7; i++) play(0, i, 0, lat);
    check("pontos_7r", 32'(pontos), 32'd74);
    play(0, 7, 0, lat);
    check("pontos_perfect", 32'(pontos), 32'd100);
    check("perfect_set",    32'(perfect), 32'd1);
    check("over_set",       32'(game_over), 32'd1);
    pulse(0, 0, 0);
    tick();
    check("drop_after_over", 32'(erro_seq), 32'd1);

    do_clear();
    for (int i = 0; i < 7; i++) play(0, i, 0, lat);
    play(0, 7, 1, lat);
    check("pontos_one_err", 32'(pontos), 32'd94);
    check("perfect_clr",    32'(perfect), 32'd0);
    check("total_one",      32'(total_erros), 32'd1);

    do_clear();
    play(0, 7, 15, lat);
    check("pen_exceeds",  32'(pontos), 32'd0);
    check("over_pen",     32'(game_over), 32'd1);
    check("total_15",     32'(total_erros), 32'd15);

    do_clear();
    pulse(0, 8, 0);
    tick();
    check("drop_range", 32'(erro_seq), 32'd1);

    do_clear();
    play(1, 0, 1, lat);
    check("hi_r1_gain0", 32'(pontos), 32'd0);
    play(1, 15, 0, lat);
    check("hi_last",      32'(pontos), 32'd11);
    check("hi_over",      32'(game_over), 32'd1);
    check("hi_perfect",   32'(perfect), 32'd0);

    do_clear();
    for (int i = 0; i < 6; i++) play(0, 6, 0, lat);
    check("clamp_100", 32'(pontos), 32'd100);
    check("clamp_over", 32'(game_over), 32'd0);

    do_clear();
    for (int i = 0; i < 18; i++) play(1, 0, 15, lat);
    check("total_sat", 32'(total_erros), 32'd255);

    do_clear();
    play(0, 0, 0, lat);
    pulse(0, 1, 0);
    tick();
    tick();
    pulse(0, 2, 0);
    check("drop_in_div", 32'(erro_seq), 32'd1);
    check("busy_in_div", 32'(busy), 32'd1);
    do_clear();
    repeat (20) tick();
    check("abort_pontos", 32'(pontos), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
